// File: rtl/sw_cond_pkg.sv
// Shared types and defaults for the slide-switch conditioner.
// Build option: define SW_EDGE_LATCH_EN to add the sticky edge-latch ports on the top level.
package sw_cond_pkg;

    typedef enum logic {
        SW_STABLE,
        SW_COUNTING
    } sw_state_t;

    localparam int unsigned SW_DEFAULT_DEBOUNCE = 500000;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-FF synchroniser, debounce counter FSM and one-cycle change pulse.
// Build option: unaffected by SW_EDGE_LATCH_EN.
module sw_debounce_bit
    import sw_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = SW_DEFAULT_DEBOUNCE,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic stable_o,
    output logic changed_o,
    output logic accept_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    sw_state_t        state_q;
    sw_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             changed_q;
    logic             changed_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stable_d  = stable_q;
        changed_d = 1'b0;
        case (state_q)
            SW_STABLE: begin
                if (sync2_q != stable_q) begin
                    state_d = SW_COUNTING;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            SW_COUNTING: begin
                if (sync2_q == stable_q) begin
                    state_d = SW_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Terminal compare doubles as saturation: the counter never passes CNT_LAST.
                    stable_d  = sync2_q;
                    changed_d = 1'b1;
                    state_d   = SW_STABLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = SW_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= SW_STABLE;
            cnt_q     <= '0;
            stable_q  <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            sync1_q   <= raw_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            changed_q <= changed_d;
        end
    end

    assign stable_o  = stable_q;
    assign changed_o = changed_q;
    // Next-cycle pulse, so the top can register SW_any_change alongside SW_changed.
    assign accept_o  = changed_d;

endmodule

// File: rtl/sw_input_conditioner.sv
// Slide-switch conditioner: per-bit synchronise + debounce, change pulses and their OR.
// Build option: SW_EDGE_LATCH_EN adds Edge_clear / SW_edge_latched (set-wins sticky edge flags).
module sw_input_conditioner
    import sw_cond_pkg::*;
#(
    parameter int unsigned NUM_SW          = 10,
    parameter int unsigned DEBOUNCE_CYCLES = SW_DEFAULT_DEBOUNCE
) (
    input  logic              Clock,
    input  logic              Reset_L,
    input  logic [NUM_SW-1:0] SW_raw,
    output logic [NUM_SW-1:0] SW_stable,
    output logic [NUM_SW-1:0] SW_changed,
    output logic              SW_any_change
`ifdef SW_EDGE_LATCH_EN
    ,
    input  logic [NUM_SW-1:0] Edge_clear,
    output logic [NUM_SW-1:0] SW_edge_latched
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [NUM_SW-1:0] accept;
    logic              any_change_q;
    logic              any_change_d;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk_i    (Clock),
            .rst_ni   (Reset_L),
            .raw_i    (SW_raw[i]),
            .stable_o (SW_stable[i]),
            .changed_o(SW_changed[i]),
            .accept_o (accept[i])
        );
    end

    assign any_change_d = |accept;

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            any_change_q <= 1'b0;
        end else begin
            any_change_q <= any_change_d;
        end
    end

    assign SW_any_change = any_change_q;

`ifdef SW_EDGE_LATCH_EN
    logic [NUM_SW-1:0] edge_q;
    logic [NUM_SW-1:0] edge_d;

    // OR-ing the pulse in last makes a set win over a simultaneous clear.
    assign edge_d = (edge_q & ~Edge_clear) | SW_changed;

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            edge_q <= '0;
        end else begin
            edge_q <= edge_d;
        end
    end

    assign SW_edge_latched = edge_q;
`endif

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Directed self-checking bench for sw_input_conditioner with DEBOUNCE_CYCLES=4, NUM_SW=10.
// Build option: edge-latch scenario runs only when SW_EDGE_LATCH_EN is defined.
module tb_sw_input_conditioner;

    localparam int unsigned NSW = 10;
    localparam int unsigned DB  = 4;

    logic           Clock;
    logic           Reset_L;
    logic [NSW-1:0] SW_raw;
    logic [NSW-1:0] SW_stable;
    logic [NSW-1:0] SW_changed;
    logic           SW_any_change;
`ifdef SW_EDGE_LATCH_EN
    logic [NSW-1:0] Edge_clear;
    logic [NSW-1:0] SW_edge_latched;
`endif

    int checks = 0;
    int errors = 0;

    sw_input_conditioner #(
        .NUM_SW         (NSW),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .Clock        (Clock),
        .Reset_L      (Reset_L),
        .SW_raw       (SW_raw),
        .SW_stable    (SW_stable),
        .SW_changed   (SW_changed),
        .SW_any_change(SW_any_change)
`ifdef SW_EDGE_LATCH_EN
        ,
        .Edge_clear     (Edge_clear),
        .SW_edge_latched(SW_edge_latched)
`endif
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, want finished)");
        $fatal(1, "timeout");
    end

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // Called at edge+1: reset pulse fully between edges, leaving raw at zero.
    task automatic do_reset();
        SW_raw  = '0;
`ifdef SW_EDGE_LATCH_EN
        Edge_clear = '0;
`endif
        Reset_L = 1'b0;
        #2;
        Reset_L = 1'b1;
    endtask

    task automatic test_reset();
        logic [NSW-1:0] exp_st;
        logic [NSW-1:0] exp_ch;
        SW_raw  = '1;
        Reset_L = 1'b0;
        tick(3);
        checks++;
        if (SW_stable !== '0) begin
            errors++;
            $display("FAIL reset_stable: got %h want %h", SW_stable, 10'h000);
        end
        checks++;
        if (SW_changed !== '0 || SW_any_change !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: got changed=%h any=%b want 000/0", SW_changed, SW_any_change);
        end
        #2;
        Reset_L = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            exp_st = (k >= 6) ? 10'h3FF : 10'h000;
            exp_ch = (k == 6) ? 10'h3FF : 10'h000;
            checks++;
            if (SW_stable !== exp_st) begin
                errors++;
                $display("FAIL reset_release_stable edge%0d: got %h want %h", k, SW_stable, exp_st);
            end
            checks++;
            if (SW_changed !== exp_ch) begin
                errors++;
                $display("FAIL reset_release_changed edge%0d: got %h want %h", k, SW_changed, exp_ch);
            end
            checks++;
            if (SW_any_change !== (k == 6)) begin
                errors++;
                $display("FAIL reset_release_any edge%0d: got %b want %b", k, SW_any_change, (k == 6));
            end
        end
    endtask

    task automatic test_clean_step();
        logic [NSW-1:0] exp_st;
        logic [NSW-1:0] exp_ch;
        do_reset();
        tick(1);
        SW_raw = 10'h008;
        for (int k = 0; k <= 7; k++) begin
            tick(1);
            exp_st = (k >= 5) ? 10'h008 : 10'h000;
            exp_ch = (k == 5) ? 10'h008 : 10'h000;
            checks++;
            if (SW_stable !== exp_st) begin
                errors++;
                $display("FAIL step_stable edge%0d: got %h want %h", k, SW_stable, exp_st);
            end
            checks++;
            if (SW_changed !== exp_ch || SW_any_change !== (k == 5)) begin
                errors++;
                $display("FAIL step_changed edge%0d: got %h/%b want %h/%b", k, SW_changed, SW_any_change, exp_ch, (k == 5));
            end
        end
    endtask

    task automatic test_bounce();
        logic [15:0] pattern;
        do_reset();
        tick(1);
        // Per-cycle raw[0]: 1,1,1,0,0,1,1,1, then 0 for the rest.
        pattern = 16'b0000_0000_1110_0111;
        for (int k = 0; k < 16; k++) begin
            SW_raw = {9'b0, pattern[k]};
            tick(1);
            checks++;
            if (SW_stable !== '0 || SW_changed !== '0 || SW_any_change !== 1'b0) begin
                errors++;
                $display("FAIL bounce cycle%0d: got stable=%h changed=%h any=%b want 000/000/0", k, SW_stable, SW_changed, SW_any_change);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [NSW-1:0] exp_st;
        do_reset();
        tick(1);
        SW_raw = 10'h080;
        tick(8);
        checks++;
        if (SW_stable !== 10'h080) begin
            errors++;
            $display("FAIL mid_preload: got %h want %h", SW_stable, 10'h080);
        end
        SW_raw = 10'h0A0;
        tick(4);
        #2;
        Reset_L = 1'b0;
        #1;
        checks++;
        if (SW_stable !== '0 || SW_changed !== '0 || SW_any_change !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_clear: got stable=%h changed=%h any=%b want 000/000/0", SW_stable, SW_changed, SW_any_change);
        end
        #2;
        Reset_L = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            tick(1);
            exp_st = (k >= 5) ? 10'h0A0 : 10'h000;
            checks++;
            if (SW_stable !== exp_st) begin
                errors++;
                $display("FAIL mid_recount_stable edge%0d: got %h want %h", k, SW_stable, exp_st);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [NSW-1:0] exp_ch;
        do_reset();
        tick(1);
        SW_raw = 10'h201;
        for (int k = 0; k <= 7; k++) begin
            tick(1);
            exp_ch = (k == 5) ? 10'h201 : 10'h000;
            checks++;
            if (SW_changed !== exp_ch) begin
                errors++;
                $display("FAIL simul_changed edge%0d: got %h want %h", k, SW_changed, exp_ch);
            end
            checks++;
            if (SW_any_change !== (k == 5)) begin
                errors++;
                $display("FAIL simul_any edge%0d: got %b want %b", k, SW_any_change, (k == 5));
            end
        end
        checks++;
        if (SW_stable !== 10'h201) begin
            errors++;
            $display("FAIL simul_stable: got %h want %h", SW_stable, 10'h201);
        end
    endtask

`ifdef SW_EDGE_LATCH_EN
    task automatic test_edge_latch();
        do_reset();
        tick(1);
        SW_raw = 10'h004;
        tick(6);
        checks++;
        if (SW_changed !== 10'h004 || SW_edge_latched !== 10'h000) begin
            errors++;
            $display("FAIL latch_pre: got changed=%h latched=%h want 004/000", SW_changed, SW_edge_latched);
        end
        Edge_clear = 10'h004;
        tick(1);
        checks++;
        if (SW_edge_latched !== 10'h004) begin
            errors++;
            $display("FAIL latch_set_wins: got %h want %h", SW_edge_latched, 10'h004);
        end
        Edge_clear = '0;
        tick(2);
        checks++;
        if (SW_edge_latched !== 10'h004) begin
            errors++;
            $display("FAIL latch_hold: got %h want %h", SW_edge_latched, 10'h004);
        end
        Edge_clear = 10'h004;
        tick(1);
        checks++;
        if (SW_edge_latched !== 10'h000) begin
            errors++;
            $display("FAIL latch_clear: got %h want %h", SW_edge_latched, 10'h000);
        end
        Edge_clear = '0;
    endtask
`endif

    initial begin
        Reset_L = 1'b0;
        SW_raw  = '0;
`ifdef SW_EDGE_LATCH_EN
        Edge_clear = '0;
`endif
        tick(1);
        test_reset();
        test_clean_step();
        test_bounce();
        test_reset_mid();
        test_simultaneous();
`ifdef SW_EDGE_LATCH_EN
        test_edge_latch();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
